// File: rtl/store_buffer.sv
// store_buffer: FIFO write buffer in front of dataMemory; loads bypass, same-word loads wait for drain
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stReq,
    input  logic [31:0] stAddr,
    input  logic [31:0] stData,
    input  logic [2:0]  stFunc3,
    input  logic        ldReq,
    input  logic [31:0] ldAddr,
    input  logic [2:0]  ldFunc3,
    input  logic [31:0] memData,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [2:0]  memFunc3,
    output logic        memWrite,
    output logic        memRead,
    output logic [31:0] ldData,
    output logic        ldValid,
    output logic        stall,
    output logic        stMisalign,
    output logic        bufEmpty
);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] e_addr [DEPTH];
    logic [31:0]       e_data [DEPTH];
    logic [2:0]        e_f3   [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PW-1:0]     head, tail;
    logic [PW:0]       count;
    logic              full, misaligned, conflict, load_go, drain, enq;
    logic              unused_bits;

    assign unused_bits = ^stAddr[31:ADDR_W];

    // Flag any valid entry sharing the load's word; byte overlap is not refined
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (valid[i] && e_addr[i][ADDR_W-1:2] == ldAddr[ADDR_W-1:2])
                conflict = 1'b1;
        conflict = conflict & ldReq;
    end

    // Port arbitration: a clean load owns the port, otherwise the head entry drains
    always_comb begin
        full       = count == (PW+1)'(DEPTH);
        misaligned = (stFunc3 == 3'b010 && stAddr[1:0] != 2'b00) || (stFunc3 == 3'b001 && stAddr[0]);
        load_go    = rst_n && ldReq && !conflict && !stReq;
        drain      = rst_n && !load_go && count != '0;
        enq        = stReq && !misaligned && !full;
        stall      = (stReq && !misaligned && full) || (ldReq && (conflict || stReq));
        stMisalign = stReq && misaligned;
        bufEmpty   = count == '0;
        memRead    = load_go;
        memWrite   = drain;
        ldValid    = load_go;
        ldData     = load_go ? memData : '0;
        memAddr    = load_go ? ldAddr : drain ? {{(32-ADDR_W){1'b0}}, e_addr[head]} : '0;
        memWdata   = drain ? e_data[head] : '0;
        memFunc3   = load_go ? ldFunc3 : drain ? e_f3[head] : 3'b000;
    end

    // Pointers, occupancy and valid bits; reset discards pending stores
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (enq) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            if (drain) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            count <= count + {{PW{1'b0}}, enq} - {{PW{1'b0}}, drain};
        end
    end

    // Entry payload storage; validity is tracked separately so no reset is needed
    always_ff @(posedge clk) begin
        if (rst_n && enq) begin
            e_addr[tail] <= stAddr[ADDR_W-1:0];
            e_data[tail] <= stData;
            e_f3[tail]   <= stFunc3;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and random checks of store_buffer against a queue-based model
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic        clk, rst_n, stReq, ldReq, memWrite, memRead, ldValid, stall, stMisalign, bufEmpty;
    logic [31:0] stAddr, stData, ldAddr, memData, memAddr, memWdata, ldData;
    logic [2:0]  stFunc3, ldFunc3, memFunc3;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
        logic [2:0]  f;
    } st_t;

    st_t         q[$];
    logic [7:0]  mem  [1024];
    logic [7:0]  gold [1024];
    int          tests, failed, illegal;
    logic [31:0] last_ld;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .stReq(stReq), .stAddr(stAddr), .stData(stData),
        .stFunc3(stFunc3), .ldReq(ldReq), .ldAddr(ldAddr), .ldFunc3(ldFunc3),
        .memData(memData), .memAddr(memAddr), .memWdata(memWdata), .memFunc3(memFunc3),
        .memWrite(memWrite), .memRead(memRead), .ldData(ldData), .ldValid(ldValid),
        .stall(stall), .stMisalign(stMisalign), .bufEmpty(bufEmpty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dataMemory stand-in: byte array, writes commit on the edge
    always @(posedge clk) begin
        if (memWrite) begin
            mem[memAddr[9:0]] <= memWdata[7:0];
            if (memFunc3 != 3'b000) mem[memAddr[9:0] + 10'd1] <= memWdata[15:8];
            if (memFunc3 == 3'b010) begin
                mem[memAddr[9:0] + 10'd2] <= memWdata[23:16];
                mem[memAddr[9:0] + 10'd3] <= memWdata[31:24];
            end
        end
    end

    // dataMemory stand-in: combinational load with RISC-V extension rules
    always_comb begin
        case (memFunc3)
            3'b000:  memData = {{24{mem[memAddr[9:0]][7]}}, mem[memAddr[9:0]]};
            3'b001:  memData = {{16{mem[memAddr[9:0] + 10'd1][7]}}, mem[memAddr[9:0] + 10'd1], mem[memAddr[9:0]]};
            3'b010:  memData = {mem[memAddr[9:0] + 10'd3], mem[memAddr[9:0] + 10'd2], mem[memAddr[9:0] + 10'd1], mem[memAddr[9:0]]};
            3'b100:  memData = {24'd0, mem[memAddr[9:0]]};
            3'b101:  memData = {16'd0, mem[memAddr[9:0] + 10'd1], mem[memAddr[9:0]]};
            default: memData = 32'd0;
        endcase
    end

    function automatic logic [31:0] gold_rd(input logic [9:0] a, input logic [2:0] f);
        logic [7:0] b0, b1, b2, b3;
        b0 = gold[a]; b1 = gold[a + 10'd1]; b2 = gold[a + 10'd2]; b3 = gold[a + 10'd3];
        case (f)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b010:  return {b3, b2, b1, b0};
            3'b100:  return {24'd0, b0};
            3'b101:  return {16'd0, b1, b0};
            default: return 32'd0;
        endcase
    endfunction

    task automatic commit(input st_t s);
        gold[s.a] = s.d[7:0];
        if (s.f != 3'b000) gold[s.a + 10'd1] = s.d[15:8];
        if (s.f == 3'b010) begin
            gold[s.a + 10'd2] = s.d[23:16];
            gold[s.a + 10'd3] = s.d[31:24];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive, predict from the queue model, check, then advance the model
    task automatic step(input logic sr, input logic [31:0] sa, input logic [31:0] sd, input logic [2:0] sf,
                        input logic lr, input logic [31:0] la, input logic [2:0] lf);
        int   n;
        logic mis, conf, lgo, drn, enq, est;
        st_t  s;
        stReq = sr; stAddr = sa; stData = sd; stFunc3 = sf;
        ldReq = lr; ldAddr = la; ldFunc3 = lf;
        #1;
        n    = q.size();
        mis  = sr && ((sf == 3'b010 && sa[1:0] != 2'b00) || (sf == 3'b001 && sa[0]));
        conf = 1'b0;
        foreach (q[i]) if (q[i].a[9:2] == la[9:2]) conf = 1'b1;
        conf = conf && lr;
        lgo  = lr && !conf && !sr;
        drn  = !lgo && n > 0;
        est  = (sr && !mis && n == DEPTH) || (lr && (conf || sr));
        enq  = sr && !mis && n != DEPTH;
        if (sr && lr) illegal++;
        chk("stall", {31'd0, stall}, {31'd0, est});
        chk("ldValid", {31'd0, ldValid}, {31'd0, lgo});
        chk("memRead", {31'd0, memRead}, {31'd0, lgo});
        chk("memWrite", {31'd0, memWrite}, {31'd0, drn});
        chk("stMisalign", {31'd0, stMisalign}, {31'd0, mis});
        chk("bufEmpty", {31'd0, bufEmpty}, {31'd0, n == 0});
        if (lgo) begin
            chk("ldData", ldData, gold_rd(la[9:0], lf));
            chk("ld_memAddr", memAddr, la);
        end
        if (drn) begin
            chk("wr_memAddr", memAddr, {22'd0, q[0].a});
            chk("wr_memWdata", memWdata, q[0].d);
            chk("wr_memFunc3", {29'd0, memFunc3}, {29'd0, q[0].f});
        end
        last_ld = ldData;
        @(posedge clk);
        if (drn) begin
            commit(q[0]);
            void'(q.pop_front());
        end
        if (enq) begin
            s.a = sa[9:0]; s.d = sd; s.f = sf;
            q.push_back(s);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0, 3'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stReq = 1'b0; ldReq = 1'b0;
        @(posedge clk);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        automatic logic [2:0] lfs [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        tests = 0; failed = 0; illegal = 0; last_ld = '0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'd0;
            gold[i] = 8'd0;
        end
        stAddr = '0; stData = '0; stFunc3 = '0; ldAddr = '0; ldFunc3 = '0;
        rst_n = 1'b0; stReq = 1'b0; ldReq = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();
        chk("rst_memWrite", {31'd0, memWrite}, 32'd0);
        chk("rst_memRead", {31'd0, memRead}, 32'd0);
        chk("rst_ldValid", {31'd0, ldValid}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_stMisalign", {31'd0, stMisalign}, 32'd0);
        chk("rst_bufEmpty", {31'd0, bufEmpty}, 32'd1);
        chk("rst_memAddr", memAddr, 32'd0);
        chk("rst_memWdata", memWdata, 32'd0);
        chk("rst_ldData", ldData, 32'd0);
        chk("rst_memFunc3", {29'd0, memFunc3}, 32'd0);
        @(negedge clk);

        step(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0, 32'd0, 3'd0);
        idle();
        chk("sw_then_empty", {31'd0, bufEmpty}, 32'd1);
        step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h10, 3'b010);
        chk("lw_deadbeef", last_ld, 32'hDEADBEEF);

        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h200 + 32'(i * 4), 32'h1000 + 32'(i), 3'b010, 1'b1, 32'h100, 3'b010);
        for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) idle();
        chk("fill_drained", {31'd0, bufEmpty}, 32'd1);

        step(1'b1, 32'h21, 32'hAB, 3'b000, 1'b0, 32'd0, 3'd0);
        step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h22, 3'b100);
        step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h22, 3'b100);
        chk("lbu_0x22", last_ld, 32'h0);
        step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h21, 3'b000);
        chk("lb_sext", last_ld, 32'hFFFFFFAB);

        step(1'b1, 32'h12, 32'h55, 3'b010, 1'b0, 32'd0, 3'd0);
        step(1'b1, 32'h13, 32'h66, 3'b001, 1'b0, 32'd0, 3'd0);
        idle();

        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 32'h0, 32'(i), 3'b001, 1'b0, 32'd0, 3'd0);
            step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h100, 3'b101);
        end
        idle();
        step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h0, 3'b101);
        chk("wrap_lhu", last_ld, 32'hA);

        step(1'b1, 32'h40, 32'h11111111, 3'b010, 1'b0, 32'd0, 3'd0);
        step(1'b1, 32'h44, 32'h22222222, 3'b010, 1'b0, 32'd0, 3'd0);
        do_reset();
        chk("midrst_bufEmpty", {31'd0, bufEmpty}, 32'd1);
        chk("midrst_memWrite", {31'd0, memWrite}, 32'd0);
        @(negedge clk);
        step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h44, 3'b010);
        chk("discarded_0x44", last_ld, 32'h0);
        step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h40, 3'b010);
        chk("drained_0x40", last_ld, 32'h11111111);

        for (int it = 0; it < 400; it++) begin
            int          r;
            logic [31:0] sa, la;
            logic [2:0]  sf, lf;
            r  = int'($urandom_range(0, 9));
            sf = 3'($urandom_range(0, 2));
            sa = 32'($urandom_range(0, 15) * 4);
            if (sf == 3'b001) sa = sa + 32'($urandom_range(0, 1) * 2);
            if (sf == 3'b000) sa = sa + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) sa = sa + 32'd1;
            lf = lfs[$urandom_range(0, 4)];
            la = 32'($urandom_range(0, 15) * 4);
            if (lf == 3'b001 || lf == 3'b101) la = la + 32'($urandom_range(0, 1) * 2);
            if (lf == 3'b000 || lf == 3'b100) la = la + 32'($urandom_range(0, 3));
            step(r < 4, sa, $urandom, sf, r >= 3 && r < 8, la, lf);
        end
        for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) idle();
        chk("final_empty", {31'd0, bufEmpty}, 32'd1);
        for (int w = 0; w < 16; w++) begin
            step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'(w * 4), 3'b010);
            chk("final_word", last_ld, gold_rd(10'(w * 4), 3'b010));
        end

        $display("[TB] note: %0d cycles carried the illegal stReq+ldReq combination", illegal);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
